l2_cache_tag_lookup: RTL
========================

Name: l2_cache_tag_lookup

Overview:
Parametrised next-generation L2 tag stage. It looks up tag, valid and dirty state for all ways of one set. It compares the stored tags against the request tag inside the stage and presents hit information one cycle later. Unlike a free-running tag stage, it supports valid/ready backpressure with a held output that snoops metadata updates, and it uses SRAM-based valid bits cleared by a set-walking init/invalidate-all sequencer. It sits between the L2 arbiter and the L2 read stage.

Parameters:
NUM_WAYS, 8, ways per set (power of two, >=2)
NUM_SETS, 256, sets (power of two)
TAG_WIDTH, 18, stored tag bits
PAYLOAD_WIDTH, 64, opaque request bits passed through unmodified

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
req_valid  in  1  lookup request
req_ready  out  1  stage can accept a request
req_set  in  log2(NUM_SETS)  set index
req_tag  in  TAG_WIDTH  tag to compare
req_payload  in  PAYLOAD_WIDTH  passthrough
upd_tag_en  in  NUM_WAYS  per-way tag/valid write
upd_tag_set  in  log2(NUM_SETS)  set for tag write
upd_tag_value  in  TAG_WIDTH  new tag
upd_tag_valid  in  1  new valid bit
upd_dirty_en  in  NUM_WAYS  per-way dirty write
upd_dirty_set  in  log2(NUM_SETS)  set for dirty write
upd_dirty_value  in  1  new dirty bit
inval_all  in  1  pulse: invalidate entire cache
out_valid  out  1  lookup result valid
out_ready  in  1  downstream accepts result
out_set, out_tag_req, out_payload  out  widths as inputs  registered request fields
out_way_valid  out  NUM_WAYS  per-way valid
out_way_tag  out  NUM_WAYS*TAG_WIDTH  per-way tags, way 0 in LSBs
out_way_dirty  out  NUM_WAYS  per-way dirty
out_hit  out  1  some valid way matches out_tag_req
out_hit_oh  out  NUM_WAYS  one-hot hit vector
out_hit_way  out  log2(NUM_WAYS)  encoded lowest hitting way
out_multi_hit  out  1  more than one way hit (error)
init_busy  out  1  init/invalidate sequence in progress

Behaviour:
- Reset (async assert): state=INIT, init counter=0, out_valid=0, init_busy=1, req_ready=0. Data outputs are don't-care but registered fields reset to 0.
- States: INIT -> RUN -> DRAIN -> INIT.
- INIT: each cycle writes valid=0 and dirty=0 to set[counter] for all ways, then counter++. After NUM_SETS cycles (counter wraps to 0), go to RUN; init_busy falls on that same edge. upd_* inputs are ignored during INIT.
- RUN: req_ready = !out_valid || out_ready. Handshake req_valid&&req_ready issues an SRAM read; the result appears with out_valid=1 on the next cycle (latency 1).
- RUN stall: if out_valid && !out_ready, all out_* registers hold. A tag or dirty update whose set equals out_set is merged into the held per-way fields on that edge, and hit outputs recompute from the merged values.
- Read-during-write to the same set on an accept cycle returns the new data (bypass) for tag, valid and dirty independently.
- inval_all in RUN: go to DRAIN; req_ready=0. Once out_valid=0 (entry consumed), go to INIT with counter=0. inval_all during DRAIN or INIT is ignored.
- Hit logic (combinational from output registers): hit_oh[w] = way_valid[w] && way_tag[w]==out_tag_req. out_hit = |hit_oh. out_hit_way = lowest set index, 0 if none. out_multi_hit = popcount>1.
- Simultaneous tag and dirty updates to different sets are both applied.
- Reset asserted mid-INIT restarts the counter at 0.

Optional Feature:
L2_TAG_PARITY_EN: each tag SRAM stores an even-parity bit, and output out_parity_err[NUM_WAYS] is added. A way with a parity mismatch forces hit_oh[w]=0 and sets its err bit. Merged/bypassed updates carry freshly computed parity. Without the macro, no parity storage and no port.

Test Plan:
- Reset, NUM_SETS=256 -> init_busy=1 and req_ready=0 for exactly 256 cycles, then req_ready=1; lookup of set 5 gives out_way_valid=0, out_hit=0.
- Write way 3 set 0x12 tag 0x155 valid=1, then lookup set 0x12 tag 0x155 -> next cycle out_hit=1, out_hit_way=3, out_hit_oh=0x08.
- Accept a lookup of set 0x40 with out_ready=0 for 3 cycles, write way 1 set 0x40 tag=req_tag valid=1 during the stall -> out_hit rises the cycle after the write, fields held, req_ready=0 until out_ready=1.
- Same-cycle write of dirty=1 to way 2 set 7 and accept of a lookup of set 7 -> out_way_dirty[2]=1.
- Pending held output, pulse inval_all -> DRAIN until out_ready, then 256 INIT cycles; a later lookup of a previously hit set -> out_hit=0.
- With L2_TAG_PARITY_EN, force a bit flip in way 0's stored tag -> out_parity_err[0]=1, out_hit_oh[0]=0.

Source files
------------

// File: rtl/l2_cache_tag_lookup_if.sv
// Request, metadata-update and result bundle for the L2 tag lookup stage.
// Defining L2_TAG_PARITY_EN adds out_parity_err.
interface l2_cache_tag_lookup_if #(
   parameter int NUM_WAYS      = 8,
   parameter int NUM_SETS      = 256,
   parameter int TAG_WIDTH     = 18,
   parameter int PAYLOAD_WIDTH = 64
);
   localparam int SET_W = $clog2(NUM_SETS);
   localparam int WAY_W = $clog2(NUM_WAYS);

   logic                          req_valid;
   logic                          req_ready;
   logic [SET_W-1:0]              req_set;
   logic [TAG_WIDTH-1:0]          req_tag;
   logic [PAYLOAD_WIDTH-1:0]      req_payload;
   logic [NUM_WAYS-1:0]           upd_tag_en;
   logic [SET_W-1:0]              upd_tag_set;
   logic [TAG_WIDTH-1:0]          upd_tag_value;
   logic                          upd_tag_valid;
   logic [NUM_WAYS-1:0]           upd_dirty_en;
   logic [SET_W-1:0]              upd_dirty_set;
   logic                          upd_dirty_value;
   logic                          inval_all;
   logic                          out_valid;
   logic                          out_ready;
   logic [SET_W-1:0]              out_set;
   logic [TAG_WIDTH-1:0]          out_tag_req;
   logic [PAYLOAD_WIDTH-1:0]      out_payload;
   logic [NUM_WAYS-1:0]           out_way_valid;
   logic [NUM_WAYS*TAG_WIDTH-1:0] out_way_tag;
   logic [NUM_WAYS-1:0]           out_way_dirty;
   logic                          out_hit;
   logic [NUM_WAYS-1:0]           out_hit_oh;
   logic [WAY_W-1:0]              out_hit_way;
   logic                          out_multi_hit;
`ifdef L2_TAG_PARITY_EN
   logic [NUM_WAYS-1:0]           out_parity_err;
`endif
   logic                          init_busy;

   modport master (
      output req_valid, req_set, req_tag, req_payload,
      output upd_tag_en, upd_tag_set, upd_tag_value, upd_tag_valid,
      output upd_dirty_en, upd_dirty_set, upd_dirty_value, inval_all, out_ready,
      input  req_ready, out_valid, out_set, out_tag_req, out_payload,
      input  out_way_valid, out_way_tag, out_way_dirty,
      input  out_hit, out_hit_oh, out_hit_way, out_multi_hit,
`ifdef L2_TAG_PARITY_EN
      input  out_parity_err,
`endif
      input  init_busy
   );

   modport slave (
      input  req_valid, req_set, req_tag, req_payload,
      input  upd_tag_en, upd_tag_set, upd_tag_value, upd_tag_valid,
      input  upd_dirty_en, upd_dirty_set, upd_dirty_value, inval_all, out_ready,
      output req_ready, out_valid, out_set, out_tag_req, out_payload,
      output out_way_valid, out_way_tag, out_way_dirty,
      output out_hit, out_hit_oh, out_hit_way, out_multi_hit,
`ifdef L2_TAG_PARITY_EN
      output out_parity_err,
`endif
      output init_busy
   );
endinterface

// File: rtl/l2_cache_tag_lookup.sv
// L2 tag stage: per-way tag/valid/dirty lookup with backpressured, snooping output register.
// Optional macro L2_TAG_PARITY_EN stores an even-parity bit per tag and reports per-way errors.
module l2_cache_tag_lookup #(
   parameter int NUM_WAYS      = 8,
   parameter int NUM_SETS      = 256,
   parameter int TAG_WIDTH     = 18,
   parameter int PAYLOAD_WIDTH = 64
) (
   input logic                  clk,
   input logic                  reset_n,
   l2_cache_tag_lookup_if.slave tl
);
   localparam int SET_W = $clog2(NUM_SETS);
   localparam int WAY_W = $clog2(NUM_WAYS);
`ifdef L2_TAG_PARITY_EN
   localparam int ENT_W = TAG_WIDTH + 1;
`else
   localparam int ENT_W = TAG_WIDTH;
`endif

   typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_DRAIN} state_t;

   state_t                     state_reg, state_next;
   logic [SET_W-1:0]           init_cnt_reg, init_cnt_next;
   logic                       out_valid_reg;
   logic [SET_W-1:0]           out_set_reg;
   logic [TAG_WIDTH-1:0]       out_tag_reg;
   logic [PAYLOAD_WIDTH-1:0]   out_payload_reg;
   logic                       req_ready;
   logic                       accept;
   logic                       upd_active;
   logic [ENT_W-1:0]           upd_entry;
   logic [WAY_W-1:0]           hit_way;
   wire  [NUM_WAYS-1:0]        way_valid_bus, way_dirty_bus, hit_oh;
   wire  [NUM_WAYS*TAG_WIDTH-1:0] way_tag_bus;
`ifdef L2_TAG_PARITY_EN
   wire  [NUM_WAYS-1:0]        parity_err;

   assign upd_entry = {^tl.upd_tag_value, tl.upd_tag_value};
`else
   assign upd_entry = tl.upd_tag_value;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= ST_INIT;
         init_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         init_cnt_reg <= init_cnt_next;
      end
   end

   // DRAIN leaves on the edge that retires the held entry, so INIT starts with out_valid low.
   always_comb begin
      state_next    = state_reg;
      init_cnt_next = init_cnt_reg;
      req_ready     = 1'b0;
      case (state_reg)
         ST_INIT: begin
            init_cnt_next = init_cnt_reg + 1'b1;
            if (init_cnt_reg == SET_W'(NUM_SETS - 1))
               state_next = ST_RUN;
         end
         ST_RUN: begin
            if (tl.inval_all)
               state_next = ST_DRAIN;
            else
               req_ready = !out_valid_reg || tl.out_ready;
         end
         ST_DRAIN: begin
            if (!out_valid_reg || tl.out_ready) begin
               state_next    = ST_INIT;
               init_cnt_next = '0;
            end
         end
         default: state_next = ST_INIT;
      endcase
   end

   assign accept     = tl.req_valid && req_ready;
   assign upd_active = (state_reg != ST_INIT);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_reg   <= 1'b0;
         out_set_reg     <= '0;
         out_tag_reg     <= '0;
         out_payload_reg <= '0;
      end else if (accept) begin
         out_valid_reg   <= 1'b1;
         out_set_reg     <= tl.req_set;
         out_tag_reg     <= tl.req_tag;
         out_payload_reg <= tl.req_payload;
      end else if (tl.out_ready) begin
         out_valid_reg   <= 1'b0;
      end
   end

   for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
      logic [ENT_W-1:0] tag_mem   [NUM_SETS];
      logic             valid_mem [NUM_SETS];
      logic             dirty_mem [NUM_SETS];
      logic [ENT_W-1:0] way_ent_reg;
      logic             way_valid_reg;
      logic             way_dirty_reg;
      logic             tag_wr, dirty_wr;

      assign tag_wr   = upd_active && tl.upd_tag_en[gi];
      assign dirty_wr = upd_active && tl.upd_dirty_en[gi];

      always_ff @(posedge clk) begin
         if (tag_wr)
            tag_mem[tl.upd_tag_set] <= upd_entry;
      end

      // The init sequencer owns the valid/dirty write ports while it walks the sets.
      always_ff @(posedge clk) begin
         if (state_reg == ST_INIT) begin
            valid_mem[init_cnt_reg] <= 1'b0;
            dirty_mem[init_cnt_reg] <= 1'b0;
         end else begin
            if (tag_wr)
               valid_mem[tl.upd_tag_set] <= tl.upd_tag_valid;
            if (dirty_wr)
               dirty_mem[tl.upd_dirty_set] <= tl.upd_dirty_value;
         end
      end

      // Accept: registered read with write-bypass. Otherwise: snoop updates to the held set.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            way_ent_reg   <= '0;
            way_valid_reg <= 1'b0;
            way_dirty_reg <= 1'b0;
         end else if (accept) begin
            if (tag_wr && tl.upd_tag_set == tl.req_set) begin
               way_ent_reg   <= upd_entry;
               way_valid_reg <= tl.upd_tag_valid;
            end else begin
               way_ent_reg   <= tag_mem[tl.req_set];
               way_valid_reg <= valid_mem[tl.req_set];
            end
            if (dirty_wr && tl.upd_dirty_set == tl.req_set)
               way_dirty_reg <= tl.upd_dirty_value;
            else
               way_dirty_reg <= dirty_mem[tl.req_set];
         end else begin
            if (tag_wr && tl.upd_tag_set == out_set_reg) begin
               way_ent_reg   <= upd_entry;
               way_valid_reg <= tl.upd_tag_valid;
            end
            if (dirty_wr && tl.upd_dirty_set == out_set_reg)
               way_dirty_reg <= tl.upd_dirty_value;
         end
      end

      assign way_tag_bus[gi*TAG_WIDTH +: TAG_WIDTH] = way_ent_reg[TAG_WIDTH-1:0];
      assign way_valid_bus[gi] = way_valid_reg;
      assign way_dirty_bus[gi] = way_dirty_reg;
`ifdef L2_TAG_PARITY_EN
      assign parity_err[gi] = way_valid_reg && (^way_ent_reg);
      assign hit_oh[gi]     = way_valid_reg && !parity_err[gi]
                              && (way_ent_reg[TAG_WIDTH-1:0] == out_tag_reg);
`else
      assign hit_oh[gi]     = way_valid_reg && (way_ent_reg[TAG_WIDTH-1:0] == out_tag_reg);
`endif
   end

   always_comb begin
      hit_way = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--)
         if (hit_oh[w])
            hit_way = WAY_W'(w);
   end

   assign tl.req_ready     = req_ready;
   assign tl.out_valid     = out_valid_reg;
   assign tl.out_set       = out_set_reg;
   assign tl.out_tag_req   = out_tag_reg;
   assign tl.out_payload   = out_payload_reg;
   assign tl.out_way_valid = way_valid_bus;
   assign tl.out_way_tag   = way_tag_bus;
   assign tl.out_way_dirty = way_dirty_bus;
   assign tl.out_hit_oh    = hit_oh;
   assign tl.out_hit       = |hit_oh;
   assign tl.out_hit_way   = hit_way;
   assign tl.out_multi_hit = ($countones(hit_oh) > 1);
   assign tl.init_busy     = (state_reg == ST_INIT);
`ifdef L2_TAG_PARITY_EN
   assign tl.out_parity_err = parity_err;
`endif
endmodule
